prog_counter_ctl: RTL

Parametrised up/down counter: the programmable successor to the team's 8-bit loadable counter. Adds configurable width and modulus, direction control, count enable, and three boundary modes (wrap, saturate, one-shot). Registered terminal-count pulse, sticky overflow flag, and the existing tri-state bus output. Sits on shared data buses as a timer/event counter.

---
 rtl/prog_counter_ctl.sv | 94 +++++++++
 1 files changed

// File: rtl/prog_counter_ctl.sv
// Programmable up/down counter with wrap, saturate and one-shot boundary
// modes. It drives a registered terminal-count pulse, a sticky overflow
// flag and a tri-state bus copy of the count.
module prog_counter_ctl #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MAX_VAL   = (longint'(1) << WIDTH) - 1,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load_e,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    input  logic             out_e,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] count_o,
    output logic             tc,
    output logic             ovf,
    output logic             halted
);

    localparam longint unsigned LIMIT = (longint'(1) << WIDTH) - 1;
    localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_C = RESET_VAL[WIDTH-1:0];

    // Reject parameter sets that would make the count leave its legal range.
    if (WIDTH < 2) begin : g_bad_width
        $error("prog_counter_ctl: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > LIMIT) begin : g_bad_max
        $error("prog_counter_ctl: MAX_VAL out of range");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_rst
        $error("prog_counter_ctl: RESET_VAL exceeds MAX_VAL");
    end

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_bnd;

    // Next-state: load beats stepping; boundary steps act by mode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q & ~clr_ovf;
        at_bnd  = up_dn ? (count_q == MAX_C) : (count_q == '0);
        if (load_e) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            state_d = RUN;
        end else if (en && state_q == RUN) begin
            if (at_bnd) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;   // a new event outranks a coincident clear
                unique case (mode)
                    2'b01:   count_d = count_q;
                    2'b10:   state_d = HALT;
                    default: count_d = up_dn ? '0 : MAX_C;
                endcase
            end else begin
                count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            count_q <= RST_C;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o  = count_q;
    assign out_data = out_e ? count_q : {WIDTH{1'bz}};
    assign tc       = tc_q;
    assign ovf      = ovf_q;
    assign halted   = (state_q == HALT);

endmodule
